maxnet_engine: RTL and testbench

Parametrised, self-sequenced winner-take-all (Maxnet) engine in signed fixed point. It accepts N competing channel values and iterates mutual lateral inhibition until at most one activation is non-zero or an iteration limit is reached. It then reports the winning channel index and that channel's original input. It succeeds the fixed 4-channel float Maxnet datapath and generalises it in channel count, width and inhibition strength, with its own controller, start/done handshake, timeout and tie reporting.

---
 rtl/maxnet_engine.sv | 144 ++++++++++++++
 tb/tb_maxnet_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_engine.sv
// Winner-take-all (Maxnet) engine: iterates lateral inhibition over N signed
// fixed-point channels until one activation survives or MAX_ITER is reached.
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int F        = 16,
  parameter int MAX_ITER = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N*W-1:0]                 x_in,
  input  logic [F-1:0]                   eps,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N)-1:0]           winner,
  output logic [W-1:0]                   max_val,
  output logic [$clog2(MAX_ITER+1)-1:0]  iterations,
  output logic                           timeout,
  output logic                           tie,
  output logic [1:0]                     dbg_state
);

  localparam int NW = $clog2(N);
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = W + $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_UPDATE, S_DONE} state_t;

  state_t                state_q;
  logic signed [W-1:0]   init_q [N];
  logic [W-1:0]          a_q [N];
  logic [F-1:0]          eps_q;
  logic [IW-1:0]         cnt_q;
  logic [SW-1:0]         sum_q;
  logic                  busy_q, done_q, timeout_q, tie_q;
  logic [NW-1:0]         winner_q;
  logic [W-1:0]          max_val_q;
  logic [IW-1:0]         iter_q;

  logic [CW-1:0]         nz_c;
  logic [SW-1:0]         sum_c;
  logic [NW-1:0]         win_a_c, win_i_c, win_c;
  logic [W-1:0]          upd_c [N];

  always_comb begin
    nz_c    = '0;
    sum_c   = '0;
    win_a_c = '0;
    win_i_c = '0;
    for (int i = 0; i < N; i++) begin
      if (a_q[i] != '0) nz_c = nz_c + CW'(1);
      sum_c = sum_c + SW'(a_q[i]);
    end
    // Strict compares keep the lowest index on equal values.
    for (int i = 1; i < N; i++) begin
      if (a_q[i] > a_q[win_a_c])       win_a_c = NW'(i);
      if (init_q[i] > init_q[win_i_c]) win_i_c = NW'(i);
    end
    win_c = (nz_c != '0) ? win_a_c : win_i_c;
  end

  // Activations are non-negative and never grow, so a sign check on the
  // widened difference replaces any saturation.
  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [SW-1:0]   d;
    logic [SW+F-1:0] prod;
    logic [SW:0]     diff;
    assign d       = sum_q - SW'(a_q[g]);
    assign prod    = (SW+F)'(d) * (SW+F)'(eps_q);
    assign diff    = {1'b0, SW'(a_q[g])} - {1'b0, SW'(prod >> F)};
    assign upd_c[g] = (diff[SW] || diff == '0) ? '0 : diff[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < N; i++) begin
        init_q[i] <= '0;
        a_q[i]    <= '0;
      end
      eps_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= '0;
      max_val_q <= '0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
      tie_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              init_q[i] <= x_in[i*W +: W];
              a_q[i]    <= x_in[i*W + W - 1] ? '0 : x_in[i*W +: W];
            end
            eps_q   <= eps;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SUM;
          end
        end
        S_SUM: begin
          if (nz_c <= CW'(1) || cnt_q == IW'(MAX_ITER)) begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            winner_q  <= win_c;
            max_val_q <= init_q[win_c];
            iter_q    <= cnt_q;
            timeout_q <= (nz_c > CW'(1));
            tie_q     <= (nz_c != CW'(1));
            state_q   <= S_DONE;
          end else begin
            sum_q   <= sum_c;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < N; i++) a_q[i] <= upd_c[i];
          cnt_q   <= cnt_q + IW'(1);
          state_q <= S_SUM;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign winner     = winner_q;
  assign max_val    = max_val_q;
  assign iterations = iter_q;
  assign timeout    = timeout_q;
  assign tie        = tie_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_maxnet_engine.sv
// Directed and randomized runs of maxnet_engine compared against an
// arithmetic Maxnet model; also covers reset and start/done protocol.
module tb_maxnet_engine;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int F  = 16;
  localparam int MI = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*W-1:0] x_in;
  logic [F-1:0]   eps;
  logic           busy, done, timeout, tie;
  logic [1:0]     winner;
  logic [W-1:0]   max_val;
  logic [4:0]     iterations;
  logic [1:0]     dbg_state;

  maxnet_engine #(.N(N), .W(W), .F(F), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .eps(eps),
    .busy(busy), .done(done), .winner(winner), .max_val(max_val),
    .iterations(iterations), .timeout(timeout), .tie(tie),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  winner;
    logic [31:0] max_val;
    logic [4:0]  iters;
    logic        timeout;
    logic        tie;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain arithmetic on the Maxnet recurrence.
  function automatic exp_t model(input logic [31:0] xs[N], input logic [15:0] e);
    longint a[N];
    longint init[N];
    longint s, na;
    int     it, nz, w;
    exp_t   r;
    it = 0;
    for (int i = 0; i < N; i++) begin
      init[i] = longint'($signed(xs[i]));
      a[i]    = (init[i] > 0) ? init[i] : 0;
    end
    while (1) begin
      nz = 0;
      s  = 0;
      for (int i = 0; i < N; i++) begin
        if (a[i] != 0) nz++;
        s += a[i];
      end
      if (nz <= 1 || it == MI) break;
      for (int i = 0; i < N; i++) begin
        na   = a[i] - ((longint'(e) * (s - a[i])) / 65536);
        a[i] = (na > 0) ? na : 0;
      end
      it++;
    end
    w = 0;
    for (int i = 1; i < N; i++) begin
      if (nz > 0) begin
        if (a[i] > a[w]) w = i;
      end else begin
        if (init[i] > init[w]) w = i;
      end
    end
    r.winner  = 2'(w);
    r.max_val = xs[w];
    r.iters   = 5'(it);
    r.timeout = (nz > 1);
    r.tie     = (nz != 1);
    r.lat     = 8'(2 * it + 1);
    return r;
  endfunction

  // driver: one full run, optional start pulse while busy
  task automatic run_case(input logic [31:0] xs[N], input logic [15:0] e,
                          input bit poke_mid, input string name);
    exp_t ex;
    int   lat;
    exp_q.push_back(model(xs, e));
    @(negedge clk);
    for (int i = 0; i < N; i++) x_in[i*W +: W] = xs[i];
    eps   = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, ".busy_run"}, busy, 1);
    lat = 0;
    while (!done && lat < 100) begin
      if (poke_mid && lat == 2) begin
        start = 1'b1;
        x_in  = {N{32'h0007_0000}};
        eps   = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      #1;
    end
    start = 1'b0;
    ex = exp_q.pop_front();
    check({name, ".latency"}, lat, ex.lat);
    check({name, ".done"}, done, 1);
    check({name, ".busy_at_done"}, busy, 0);
    check({name, ".winner"}, winner, ex.winner);
    check({name, ".max_val"}, max_val, ex.max_val);
    check({name, ".iterations"}, iterations, ex.iters);
    check({name, ".timeout"}, timeout, ex.timeout);
    check({name, ".tie"}, tie, ex.tie);
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, ".done_pulse"}, done, 0);
    check({name, ".no_restart"}, busy, 0);
    check({name, ".hold_max"}, max_val, ex.max_val);
  endtask

  initial begin
    logic [31:0] xs[N];
    int          stray;

    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    eps   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outputs", {busy, done, winner, max_val, iterations, timeout, tie},
          '0);
    @(negedge clk);
    rst = 1'b0;

    xs = '{32'h3333, 32'hE666, 32'h8000, 32'h1999};
    run_case(xs, 16'h4000, 1'b0, "normal");

    xs = '{32'h0, 32'h0, 32'h0003_0000, 32'h0};
    run_case(xs, 16'h4000, 1'b0, "single");

    xs = '{32'h8000, 32'h8000, 32'h1999, 32'h1999};
    run_case(xs, 16'h4000, 1'b0, "equal_max");

    xs = '{32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_8000, 32'hFFFD_0000};
    run_case(xs, 16'h4000, 1'b0, "all_neg");

    xs = '{32'h0001_0000, 32'h0, 32'h0002_0000, 32'h0};
    run_case(xs, 16'h0000, 1'b0, "eps_zero");

    xs = '{32'h3333, 32'hE666, 32'h8000, 32'h1999};
    run_case(xs, 16'h4000, 1'b1, "start_busy");

    // reset in the middle of a run
    @(negedge clk);
    xs = '{32'h3333, 32'hE666, 32'h8000, 32'h1999};
    for (int i = 0; i < N; i++) x_in[i*W +: W] = xs[i];
    eps   = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.outputs", {busy, done, winner, max_val, iterations, timeout, tie}, '0);
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    check("midrst.no_done", stray, 0);
    run_case(xs, 16'h4000, 1'b0, "after_rst");

    // randomized runs
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) xs[i] = $urandom_range(32'h0002_8000, 0) - 32'h8000;
      run_case(xs, 16'($urandom_range(16'hFFFF, 16'h0800)), 1'b0, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
